// File: rtl/otp_prog_pulse_ctrl_if.sv
// otp_prog_pulse_ctrl_if: controller-side signals of the OTP programming pulse timer
interface otp_prog_pulse_ctrl_if #(parameter int CNT_WIDTH = 4);
  logic prg;
  logic cell_selected;
  logic sense_blown;
  logic pulse_en;
  logic writing_successful;
  logic write_error;
  logic busy;
  logic [CNT_WIDTH-1:0] pulse_count;
  modport master (output prg, cell_selected, sense_blown,
                  input pulse_en, writing_successful, write_error, busy, pulse_count);
  modport slave (input prg, cell_selected, sense_blown,
                 output pulse_en, writing_successful, write_error, busy, pulse_count);
endinterface

// File: rtl/otp_prog_pulse_ctrl.sv
// otp_prog_pulse_ctrl: timed OTP program pulses with settle, verify and bounded retry
module otp_prog_pulse_ctrl #(
  parameter int PULSE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_PULSES = 8,
  parameter int CNT_WIDTH = $clog2(MAX_PULSES + 1)
) (
  input logic clk,
  input logic reset,
  otp_prog_pulse_ctrl_if.slave bus
);
  localparam int TW = $clog2((PULSE_CYCLES > SETTLE_CYCLES ? PULSE_CYCLES : SETTLE_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, PULSE, SETTLE, SENSE, DONE, FAIL} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic sync1, sync2, go;
  logic pulse_en_q, busy_q, ok_q, err_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      cnt <= '0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      pulse_en_q <= 1'b0;
      busy_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt <= cnt_nxt;
      sync1 <= bus.sense_blown;
      sync2 <= sync1;
      pulse_en_q <= state_nxt == PULSE;
      busy_q <= state_nxt inside {PULSE, SETTLE, SENSE};
      ok_q <= state_nxt == DONE;
      err_q <= state_nxt == FAIL;
    end
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    cnt_nxt = cnt;
    go = bus.prg & bus.cell_selected;
    case (state)
      IDLE: if (go) begin
        state_nxt = PULSE;
        timer_nxt = '0;
        cnt_nxt = CNT_WIDTH'(1);
      end
      PULSE: if (timer == TW'(PULSE_CYCLES - 1)) begin
        state_nxt = SETTLE;
        timer_nxt = '0;
      end
      SETTLE: if (timer == TW'(SETTLE_CYCLES - 1)) state_nxt = SENSE;
      SENSE: if (sync2) state_nxt = DONE;
        else if (cnt == CNT_WIDTH'(MAX_PULSES)) state_nxt = FAIL;
        else begin
          state_nxt = PULSE;
          timer_nxt = '0;
          cnt_nxt = cnt + 1'b1;
        end
      DONE, FAIL: if (!bus.cell_selected) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // losing go mid-attempt abandons the cell silently, taking priority over any verify result
    if (state inside {PULSE, SETTLE, SENSE} && !go) state_nxt = IDLE;
    if (state_nxt == IDLE) cnt_nxt = '0;
  end
  assign bus.pulse_en = pulse_en_q;
  assign bus.busy = busy_q;
  assign bus.writing_successful = ok_q;
  assign bus.write_error = err_q;
  assign bus.pulse_count = cnt;
endmodule
